fmul_pipe: RTL
==============

Name: fmul_pipe

Overview:
- Parametrised, pipelined successor to the combinational single-precision multiplier.
- Adds a valid/ready handshake with backpressure, configurable depth, and selectable rounding (truncate or round-to-nearest-even).
- Handles IEEE-754 specials (NaN/inf/zero) and flags overflow, underflow and invalid.
- Sits between the FPU issue logic and the writeback arbiter; carries a tag so results can be matched to their issuing instruction.

Parameters:
- STAGES, 2, pipeline depth in cycles, legal 1..4; input operands are never registered combinationally to output.
- ROUND, 1, rounding mode: 0 = truncate (chop), 1 = round-to-nearest-even.
- TAG_W, 5, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and tag present.
- in_ready  out  1  block accepts this cycle.
- x1  in  32  IEEE-754 single operand A.
- x2  in  32  IEEE-754 single operand B.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- y  out  32  product.
- out_tag  out  TAG_W  tag of this result.
- ovf  out  1  result overflowed to ±inf.
- udf  out  1  nonzero result flushed to ±0.
- nan  out  1  invalid operation or NaN input.

Behaviour:
- Reset (rstn=0, asynchronous): all stage valids cleared; out_valid=0, y=0, out_tag=0, ovf=udf=nan=0. in_ready=1 on the first edge after release. Operations in flight when reset asserts are discarded; none are reported.
- Handshake:
  - Transfer on in_valid & in_ready, and on out_valid & out_ready.
  - Stage k advances when stage k+1 is empty or advancing; the last stage advances when out_ready=1 or it is empty.
  - in_ready = !valid[0] | advance[0]. Full throughput is 1 op/cycle.
  - Latency is exactly STAGES cycles from accept to out_valid while out_ready is held high.
  - While out_valid=1 & out_ready=0, y/out_tag/flags hold stable.
  - Results are never dropped, duplicated or reordered.
  - Up to STAGES ops are buffered; in_ready falls once all stages are full and stalled.
  - Simultaneous accept and emit on a full pipe is allowed (no bubble).
- Arithmetic:
  - Denormal inputs (e=0) are treated as zero.
  - The product is exact: 24x24 to 48 bits on {1,m1}·{1,m2}. Normalise on P[47].
  - Biased exponent: e = e1 + e2 − 127 + P[47], computed in 10-bit signed arithmetic.
  - ROUND=0 keeps the top 24 bits.
  - ROUND=1 uses guard, round and sticky bits with ties-to-even. A mantissa carry out of rounding increments e.
  - Sign is s1^s2 for all non-NaN results, including zero and inf.
- Exceptions, in priority order:
  1. Either input NaN, or inf×0 → 0x7FC00000, nan=1.
  2. Either input inf → {s, 0xFF, 0}, ovf=0.
  3. Either input zero or denormal → {s, 0, 0}, udf=0.
  4. Final e ≥ 255 → {s, 0xFF, 0}, ovf=1.
  5. Final e ≤ 0 → {s, 0, 0}, udf=1 (flush-to-zero; no denormal output).
- Flags are per result and valid only while out_valid=1. They are 0 when out_valid=0.
- The stage split is free, provided the STAGES latency and handshake rules hold. The 48-bit multiply may not be split across a stall boundary in a way that corrupts held data.

Test Plan:
- Basic, STAGES=2, out_ready=1: 0x3FC00000 × 0x40000000, tag 3 → two cycles later y=0x40400000, out_tag=3, all flags 0.
- Rounding: 0x3FC00001 × 0x3FC00001 → ROUND=1 gives 0x40100002; ROUND=0 gives 0x40100001.
- Overflow and invalid:
  - 0x7F000000 × 0x7F000000 → 0x7F800000, ovf=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, ovf=0.
  - 0x7F800000 × 0x00000000 → 0x7FC00000, nan=1.
- Underflow: 0x00800000 × 0x00800000 → 0x00000000, udf=1. 0x80800000 × 0x3F800000 → 0x80800000, no flags.
- Backpressure:
  - Hold out_ready=0 and stream 6 ops with tags 0..5; in_ready drops after STAGES accepts.
  - Release out_ready → tags emerge in order 0..5 with correct y, no gaps once streaming, y stable during stall.
- Reset mid-stream: assert rstn=0 with 2 ops in flight → out_valid=0 immediately and y=0. After release, no stale results appear, and a new op completes with latency STAGES.

Source files
------------

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 single-precision multiplier with valid/ready handshake and tag sideband.
// The full product is formed before stage 0; later stages only carry finished results.
module fmul_pipe #(
  parameter int STAGES = 2,
  parameter int ROUND  = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             udf,
  output logic             nan
);
  localparam int L = STAGES - 1;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic             udf;
    logic             nan;
  } res_t;

  res_t res_in;

  logic              s;
  logic [7:0]        e1, e2;
  logic [22:0]       m1, m2;
  logic              inf1, inf2, zero1, zero2, invalid;
  logic [47:0]       prod;
  logic [23:0]       sig;
  logic              g, r, st, inc;
  logic [24:0]       sig_r;
  logic signed [9:0] e_f;
  logic [22:0]       frac;

  always_comb begin
    s     = x1[31] ^ x2[31];
    e1    = x1[30:23];
    e2    = x2[30:23];
    m1    = x1[22:0];
    m2    = x2[22:0];
    inf1  = (e1 == 8'hFF) && (m1 == '0);
    inf2  = (e2 == 8'hFF) && (m2 == '0);
    zero1 = (e1 == 8'h00);
    zero2 = (e2 == 8'h00);
    invalid = ((e1 == 8'hFF) && (m1 != '0)) || ((e2 == 8'hFF) && (m2 != '0)) ||
              (inf1 && zero2) || (inf2 && zero1);

    prod = {24'd0, 1'b1, m1} * {24'd0, 1'b1, m2};
    if (prod[47]) begin
      sig = prod[47:24];
      g   = prod[23];
      r   = prod[22];
      st  = |prod[21:0];
    end else begin
      sig = prod[46:23];
      g   = prod[22];
      r   = prod[21];
      st  = |prod[20:0];
    end
    inc   = (ROUND != 0) && g && (r || st || sig[0]);
    sig_r = {1'b0, sig} + {24'd0, inc};
    // a rounding carry leaves 1.000..., so the fraction collapses to zero
    frac  = sig_r[24] ? 23'd0 : sig_r[22:0];
    e_f   = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127 +
            $signed({9'd0, prod[47]}) + $signed({9'd0, sig_r[24]});

    res_in     = '0;
    res_in.tag = in_tag;
    if (invalid) begin
      res_in.y   = 32'h7FC0_0000;
      res_in.nan = 1'b1;
    end else if (inf1 || inf2) begin
      res_in.y = {s, 8'hFF, 23'd0};
    end else if (zero1 || zero2) begin
      res_in.y = {s, 31'd0};
    end else if (e_f >= 10'sd255) begin
      res_in.y   = {s, 8'hFF, 23'd0};
      res_in.ovf = 1'b1;
    end else if (e_f <= 10'sd0) begin
      res_in.y   = {s, 31'd0};
      res_in.udf = 1'b1;
    end else begin
      res_in.y = {s, e_f[7:0], frac};
    end
  end

  logic [STAGES-1:0] vld_q, vld_d, adv;
  res_t [STAGES-1:0] pipe_q, pipe_d;

  // stage k moves when any stage at or beyond it has a hole, or the sink accepts
  always_comb begin
    logic full;
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) full = full & vld_q[j];
      adv[k] = out_ready | ~full;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    pipe_d = pipe_q;
    if (adv[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) pipe_d[0] = res_in;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= '0;
      pipe_q <= '0;
    end else begin
      vld_q  <= vld_d;
      pipe_q <= pipe_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[L];
  assign y         = pipe_q[L].y;
  assign out_tag   = pipe_q[L].tag;
  assign ovf       = pipe_q[L].ovf & vld_q[L];
  assign udf       = pipe_q[L].udf & vld_q[L];
  assign nan       = pipe_q[L].nan & vld_q[L];
endmodule
